// File: rtl/vtc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vtc_pkg
//  Description : Shared types and constants for the vending transaction
//                controller: FSM state encoding, item-word field offsets
//                and credit/coin widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package vtc_pkg;

    // Item-word layout: [15:0] price, [25:16] stock, [31:26] reserved
    localparam int c_PRICE_LSB = 0;
    localparam int c_PRICE_MSB = 15;
    localparam int c_STOCK_LSB = 16;
    localparam int c_STOCK_MSB = 25;
    localparam int c_RSVD_LSB  = 26;
    localparam int c_RSVD_MSB  = 31;

    localparam int c_PRICE_W  = c_PRICE_MSB - c_PRICE_LSB + 1;
    localparam int c_STOCK_W  = c_STOCK_MSB - c_STOCK_LSB + 1;
    localparam int c_RSVD_W   = c_RSVD_MSB - c_RSVD_LSB + 1;
    localparam int c_CREDIT_W = 16;
    localparam int c_COIN_W   = 8;

    // Transaction FSM encoding
    typedef logic [2:0] vtc_state_t;
    localparam vtc_state_t c_ST_IDLE     = 3'd0;
    localparam vtc_state_t c_ST_FETCH    = 3'd1;
    localparam vtc_state_t c_ST_LOAD     = 3'd2;
    localparam vtc_state_t c_ST_COLLECT  = 3'd3;
    localparam vtc_state_t c_ST_DISPENSE = 3'd4;
    localparam vtc_state_t c_ST_CHANGE   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/vend_txn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vend_txn_ctrl
//  Description : Vending transaction controller. Takes an item selection,
//                reads the item's price/stock word, accumulates coin credit,
//                dispenses, writes back decremented stock and returns change.
//                Optional build macro VTC_TIMEOUT_EN adds an auto-refund
//                after TIMEOUT_CYCLES idle cycles in COLLECT.
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_txn_ctrl
    import vtc_pkg::*;
#(
    parameter int MAX_ITEMS      = 1024,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int AW            = $clog2(MAX_ITEMS)
) (
    input  logic                pclk,
    input  logic                prst,
    input  logic                cfg_mode,
    input  logic                item_sel_valid,
    input  logic [AW-1:0]       item_sel,
    input  logic                coin_valid,
    input  logic [c_COIN_W-1:0] coin_cents,
    input  logic                cancel,
    output logic [AW-1:0]       mem_raddr,
    input  logic [31:0]         mem_rdata,
    output logic                mem_we,
    output logic [AW-1:0]       mem_waddr,
    output logic [31:0]         mem_wdata,
    output logic                busy,
    output logic                coin_rej,
    output logic                soldout,
    output logic                dispense_valid,
    output logic [AW-1:0]       dispense_item,
    output logic                change_valid,
    output logic [15:0]         change_cents
);

    if (TIMEOUT_CYCLES < 1) begin : g_tmo_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    vtc_state_t              r_state, w_state_next;
    logic [AW-1:0]           r_item, w_item_next;
    logic [c_PRICE_W-1:0]    r_price, w_price_next;
    logic [c_STOCK_W-1:0]    r_stock, w_stock_next;
    logic [c_RSVD_W-1:0]     r_rsvd, w_rsvd_next;
    logic [c_CREDIT_W-1:0]   r_credit, w_credit_next;

    logic                    r_coin_rej, w_coin_rej;
    logic                    r_soldout, w_soldout;
    logic                    r_dispense_valid, w_dispense_valid;
    logic [AW-1:0]           r_dispense_item, w_dispense_item;
    logic                    r_change_valid, w_change_valid;
    logic [15:0]             r_change_cents, w_change_cents;
    logic                    r_mem_we, w_mem_we;
    logic [AW-1:0]           r_mem_waddr, w_mem_waddr;
    logic [31:0]             r_mem_wdata, w_mem_wdata;

    logic [c_CREDIT_W:0]     w_sum_wide;
    logic [c_CREDIT_W-1:0]   w_coin_credit;
    logic [c_PRICE_W-1:0]    w_rd_price;
    logic [c_STOCK_W-1:0]    w_rd_stock;
    logic [c_RSVD_W-1:0]     w_rd_rsvd;
    logic                    w_timeout;

    assign w_rd_price = mem_rdata[c_PRICE_MSB:c_PRICE_LSB];
    assign w_rd_stock = mem_rdata[c_STOCK_MSB:c_STOCK_LSB];
    assign w_rd_rsvd  = mem_rdata[c_RSVD_MSB:c_RSVD_LSB];

    // Coin credit with saturation at all-ones; a coin on this cycle is
    // folded in before any refund so cancel returns the full sum.
    assign w_sum_wide    = {1'b0, r_credit} + {{(c_CREDIT_W + 1 - c_COIN_W){1'b0}}, coin_cents};
    assign w_coin_credit = !coin_valid           ? r_credit :
                           w_sum_wide[c_CREDIT_W] ? {c_CREDIT_W{1'b1}} :
                                                    w_sum_wide[c_CREDIT_W-1:0];

`ifdef VTC_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0] r_tmo_cnt;

    // Idle counter: held at zero outside COLLECT and cleared by every coin
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_tmo_cnt <= '0;
        end else if (r_state != c_ST_COLLECT || coin_valid) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end

    assign w_timeout = (r_state == c_ST_COLLECT) && !coin_valid &&
                       (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output decode; all pulses are registered
    always_comb begin
        w_state_next     = r_state;
        w_item_next      = r_item;
        w_price_next     = r_price;
        w_stock_next     = r_stock;
        w_rsvd_next      = r_rsvd;
        w_credit_next    = r_credit;
        w_coin_rej       = coin_valid && (r_state != c_ST_COLLECT);
        w_soldout        = 1'b0;
        w_dispense_valid = 1'b0;
        w_dispense_item  = r_dispense_item;
        w_change_valid   = 1'b0;
        w_change_cents   = r_change_cents;
        w_mem_we         = 1'b0;
        w_mem_waddr      = r_mem_waddr;
        w_mem_wdata      = r_mem_wdata;

        case (r_state)
            c_ST_IDLE: begin
                if (item_sel_valid && !cfg_mode) begin
                    w_item_next  = item_sel;
                    w_state_next = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                w_state_next = cfg_mode ? c_ST_IDLE : c_ST_LOAD;
            end
            c_ST_LOAD: begin
                if (cfg_mode) begin
                    w_state_next = c_ST_IDLE;
                end else begin
                    w_price_next = w_rd_price;
                    w_stock_next = w_rd_stock;
                    w_rsvd_next  = w_rd_rsvd;
                    if (w_rd_stock == '0) begin
                        w_soldout    = 1'b1;
                        w_state_next = c_ST_IDLE;
                    end else if (w_rd_price == '0) begin
                        // Free item: skip coin collection entirely
                        w_dispense_valid = 1'b1;
                        w_dispense_item  = r_item;
                        w_mem_we         = 1'b1;
                        w_mem_waddr      = r_item;
                        w_mem_wdata      = {w_rd_rsvd, w_rd_stock - c_STOCK_W'(1), w_rd_price};
                        w_state_next     = c_ST_DISPENSE;
                    end else begin
                        w_state_next = c_ST_COLLECT;
                    end
                end
            end
            c_ST_COLLECT: begin
                w_credit_next = w_coin_credit;
                if (cancel || cfg_mode || w_timeout) begin
                    // Refund path: whatever credit exists (including a coin
                    // arriving this cycle) goes back, nothing is dispensed.
                    if (w_coin_credit != '0) begin
                        w_change_valid = 1'b1;
                        w_change_cents = w_coin_credit;
                    end
                    w_credit_next = '0;
                    w_state_next  = c_ST_IDLE;
                end else if (r_credit >= r_price) begin
                    w_dispense_valid = 1'b1;
                    w_dispense_item  = r_item;
                    w_mem_we         = 1'b1;
                    w_mem_waddr      = r_item;
                    w_mem_wdata      = {r_rsvd, r_stock - c_STOCK_W'(1), r_price};
                    w_state_next     = c_ST_DISPENSE;
                end
            end
            c_ST_DISPENSE: begin
                if (r_credit != r_price) begin
                    w_change_valid = 1'b1;
                    w_change_cents = r_credit - r_price;
                end
                w_state_next = c_ST_CHANGE;
            end
            c_ST_CHANGE: begin
                w_credit_next = '0;
                w_state_next  = c_ST_IDLE;
            end
            default: begin
                w_credit_next = '0;
                w_state_next  = c_ST_IDLE;
            end
        endcase
    end

    // State, transaction context and registered outputs
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_state          <= c_ST_IDLE;
            r_item           <= '0;
            r_price          <= '0;
            r_stock          <= '0;
            r_rsvd           <= '0;
            r_credit         <= '0;
            r_coin_rej       <= 1'b0;
            r_soldout        <= 1'b0;
            r_dispense_valid <= 1'b0;
            r_dispense_item  <= '0;
            r_change_valid   <= 1'b0;
            r_change_cents   <= '0;
            r_mem_we         <= 1'b0;
            r_mem_waddr      <= '0;
            r_mem_wdata      <= '0;
        end else begin
            r_state          <= w_state_next;
            r_item           <= w_item_next;
            r_price          <= w_price_next;
            r_stock          <= w_stock_next;
            r_rsvd           <= w_rsvd_next;
            r_credit         <= w_credit_next;
            r_coin_rej       <= w_coin_rej;
            r_soldout        <= w_soldout;
            r_dispense_valid <= w_dispense_valid;
            r_dispense_item  <= w_dispense_item;
            r_change_valid   <= w_change_valid;
            r_change_cents   <= w_change_cents;
            r_mem_we         <= w_mem_we;
            r_mem_waddr      <= w_mem_waddr;
            r_mem_wdata      <= w_mem_wdata;
        end
    end

    assign mem_raddr      = r_item;
    // Config block owns the memory whenever cfg_mode is high
    assign mem_we         = r_mem_we & ~cfg_mode;
    assign mem_waddr      = r_mem_waddr;
    assign mem_wdata      = r_mem_wdata;
    assign busy           = (r_state != c_ST_IDLE);
    assign coin_rej       = r_coin_rej;
    assign soldout        = r_soldout;
    assign dispense_valid = r_dispense_valid;
    assign dispense_item  = r_dispense_item;
    assign change_valid   = r_change_valid;
    assign change_cents   = r_change_cents;

endmodule
`default_nettype wire

// File: tb/tb_vend_txn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vend_txn_ctrl
//  Description : Self-checking bench for vend_txn_ctrl with a behavioural
//                item memory and an event scoreboard keyed on clock edge.
//                Build with VTC_TIMEOUT_EN to exercise the auto-refund.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_txn_ctrl;

    localparam int AW = 10;

    logic          pclk = 1'b0;
    logic          prst;
    logic          cfg_mode;
    logic          item_sel_valid;
    logic [AW-1:0] item_sel;
    logic          coin_valid;
    logic [7:0]    coin_cents;
    logic          cancel;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          coin_rej;
    logic          soldout;
    logic          dispense_valid;
    logic [AW-1:0] dispense_item;
    logic          change_valid;
    logic [15:0]   change_cents;

    vend_txn_ctrl #(
        .MAX_ITEMS      (1024),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk           (pclk),
        .prst           (prst),
        .cfg_mode       (cfg_mode),
        .item_sel_valid (item_sel_valid),
        .item_sel       (item_sel),
        .coin_valid     (coin_valid),
        .coin_cents     (coin_cents),
        .cancel         (cancel),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .mem_wdata      (mem_wdata),
        .busy           (busy),
        .coin_rej       (coin_rej),
        .soldout        (soldout),
        .dispense_valid (dispense_valid),
        .dispense_item  (dispense_item),
        .change_valid   (change_valid),
        .change_cents   (change_cents)
    );

    always #5 pclk = ~pclk;

    // Item memory: synchronous read, write-back port from the controller
    logic [31:0] mem [0:1023];
    always @(posedge pclk) begin
        mem_rdata <= mem[mem_raddr];
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    typedef struct {
        int          e;
        logic [31:0] d;
        logic [9:0]  a;
    } ev_t;

    ev_t q_disp[$];
    ev_t q_wr[$];
    ev_t q_chg[$];
    ev_t q_sold[$];
    ev_t q_rej[$];

    int edge_n      = 0;
    int vectors     = 0;
    int miscompares = 0;

    function automatic int pending();
        return q_disp.size() + q_wr.size() + q_chg.size() + q_sold.size() + q_rej.size();
    endfunction

    // Scoreboard: every output pulse must match the next expected event
    always @(posedge pclk) begin
        ev_t ev;
        edge_n = edge_n + 1;
        #1;
        if (dispense_valid) begin
            vectors++;
            if (q_disp.size() == 0) begin
                miscompares++;
                $display("FAIL dispense_unexpected: got item %0d at edge %0d, required no dispense", dispense_item, edge_n);
            end else begin
                ev = q_disp.pop_front();
                if (ev.e != edge_n || dispense_item !== ev.a) begin
                    miscompares++;
                    $display("FAIL dispense: got item %0d at edge %0d, required item %0d at edge %0d", dispense_item, edge_n, ev.a, ev.e);
                end
            end
        end
        if (mem_we) begin
            vectors++;
            if (q_wr.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected: got addr %0d data %h at edge %0d, required no write", mem_waddr, mem_wdata, edge_n);
            end else begin
                ev = q_wr.pop_front();
                if (ev.e != edge_n || mem_waddr !== ev.a || mem_wdata !== ev.d) begin
                    miscompares++;
                    $display("FAIL write: got addr %0d data %h at edge %0d, required addr %0d data %h at edge %0d", mem_waddr, mem_wdata, edge_n, ev.a, ev.d, ev.e);
                end
            end
            if (cfg_mode) begin
                miscompares++;
                $display("FAIL write_in_cfg: got mem_we=1 with cfg_mode=1, required mem_we=0");
            end
        end
        if (change_valid) begin
            vectors++;
            if (q_chg.size() == 0) begin
                miscompares++;
                $display("FAIL change_unexpected: got %0d cents at edge %0d, required no change", change_cents, edge_n);
            end else begin
                ev = q_chg.pop_front();
                if (ev.e != edge_n || change_cents !== ev.d[15:0]) begin
                    miscompares++;
                    $display("FAIL change: got %0d cents at edge %0d, required %0d cents at edge %0d", change_cents, edge_n, ev.d[15:0], ev.e);
                end
            end
        end
        if (soldout) begin
            vectors++;
            if (q_sold.size() == 0) begin
                miscompares++;
                $display("FAIL soldout_unexpected: got pulse at edge %0d, required none", edge_n);
            end else begin
                ev = q_sold.pop_front();
                if (ev.e != edge_n) begin
                    miscompares++;
                    $display("FAIL soldout: got pulse at edge %0d, required edge %0d", edge_n, ev.e);
                end
            end
        end
        if (coin_rej) begin
            vectors++;
            if (q_rej.size() == 0) begin
                miscompares++;
                $display("FAIL coin_rej_unexpected: got pulse at edge %0d, required none", edge_n);
            end else begin
                ev = q_rej.pop_front();
                if (ev.e != edge_n) begin
                    miscompares++;
                    $display("FAIL coin_rej: got pulse at edge %0d, required edge %0d", edge_n, ev.e);
                end
            end
        end
    end

    // Apply one cycle of stimulus; e returns the edge that samples it
    task automatic drive(input bit sv, input int s, input bit cv, input int c, input bit cn, output int e);
        @(negedge pclk);
        item_sel_valid = sv;
        item_sel       = AW'(s);
        coin_valid     = cv;
        coin_cents     = 8'(c);
        cancel         = cn;
        e              = edge_n + 1;
    endtask

    task automatic idle(input int n);
        int e;
        repeat (n) drive(0, 0, 0, 0, 0, e);
    endtask

    // Bounded wait for the controller to settle and all expected events to land
    task automatic settle();
        int n = 0;
        while ((busy || pending() != 0) && n < 60) begin
            idle(1);
            n++;
        end
        idle(2);
    endtask

    task automatic flush();
        q_disp.delete(); q_wr.delete(); q_chg.delete(); q_sold.delete(); q_rej.delete();
    endtask

    task automatic select_item(input int item);
        int e;
        drive(1, item, 0, 0, 0, e);
        idle(2);
    endtask

    task automatic test_reset();
        prst = 1'b1;
        idle(3);
        vectors++;
        if ({busy, coin_rej, soldout, dispense_valid, change_valid, mem_we} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got busy/rej/sold/disp/chg/we=%b, required 000000", {busy, coin_rej, soldout, dispense_valid, change_valid, mem_we});
        end
        vectors++;
        if (dispense_item !== '0 || change_cents !== '0 || mem_waddr !== '0 || mem_wdata !== '0 || mem_raddr !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got item=%0d chg=%0d waddr=%0d wdata=%h raddr=%0d, required all 0", dispense_item, change_cents, mem_waddr, mem_wdata, mem_raddr);
        end
        prst = 1'b0;
        idle(1);
    endtask

    task automatic test_vend_exact();
        int e;
        mem[5] = {6'd0, 10'd3, 16'd150};
        select_item(5);
        drive(0, 0, 1, 100, 0, e);
        drive(0, 0, 1, 50, 0, e);
        q_disp.push_back('{e + 1, 32'd0, 10'd5});
        q_wr.push_back('{e + 1, {6'd0, 10'd2, 16'd150}, 10'd5});
        settle();
        vectors++;
        if (busy !== 1'b0 || pending() != 0) begin
            miscompares++;
            $display("FAIL vend_exact_done: got busy=%0b pending=%0d, required busy=0 pending=0", busy, pending());
        end
        flush();
    endtask

    task automatic test_vend_change();
        int e;
        select_item(5);
        drive(0, 0, 1, 100, 0, e);
        drive(0, 0, 1, 100, 0, e);
        q_disp.push_back('{e + 1, 32'd0, 10'd5});
        q_wr.push_back('{e + 1, {6'd0, 10'd1, 16'd150}, 10'd5});
        q_chg.push_back('{e + 2, 32'd50, 10'd0});
        settle();
        vectors++;
        if (busy !== 1'b0 || pending() != 0) begin
            miscompares++;
            $display("FAIL vend_change_done: got busy=%0b pending=%0d, required busy=0 pending=0", busy, pending());
        end
        flush();
    endtask

    task automatic test_soldout();
        int e;
        mem[7] = {6'h2A, 10'd0, 16'd80};
        drive(1, 7, 0, 0, 0, e);
        q_sold.push_back('{e + 2, 32'd0, 10'd0});
        idle(3);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL soldout_busy: got busy=%0b after soldout, required 0", busy);
        end
        settle();
        vectors++;
        if (pending() != 0) begin
            miscompares++;
            $display("FAIL soldout_done: got pending=%0d, required 0", pending());
        end
        flush();
    endtask

    task automatic test_cancel();
        int e;
        mem[9] = {6'd0, 10'd4, 16'd200};
        select_item(9);
        drive(0, 0, 1, 25, 0, e);
        drive(0, 0, 1, 25, 0, e);
        idle(1);
        drive(0, 0, 0, 0, 1, e);
        q_chg.push_back('{e, 32'd50, 10'd0});
        settle();
        // Coin while idle is rejected and must not create credit
        drive(0, 0, 1, 40, 0, e);
        q_rej.push_back('{e, 32'd0, 10'd0});
        settle();
        // Coin and cancel together: coin counted, whole sum refunded
        select_item(9);
        drive(0, 0, 1, 25, 0, e);
        drive(0, 0, 1, 30, 1, e);
        q_chg.push_back('{e, 32'd55, 10'd0});
        settle();
        // Exact payment afterwards must produce no change
        select_item(9);
        drive(0, 0, 1, 200, 0, e);
        q_disp.push_back('{e + 1, 32'd0, 10'd9});
        q_wr.push_back('{e + 1, {6'd0, 10'd3, 16'd200}, 10'd9});
        settle();
        vectors++;
        if (busy !== 1'b0 || pending() != 0) begin
            miscompares++;
            $display("FAIL cancel_done: got busy=%0b pending=%0d, required busy=0 pending=0", busy, pending());
        end
        flush();
    endtask

    task automatic test_cfg_abort();
        int e;
        select_item(9);
        drive(0, 0, 1, 50, 0, e);
        drive(0, 0, 1, 25, 0, e);
        drive(0, 0, 0, 0, 0, e);
        cfg_mode = 1'b1;
        q_chg.push_back('{e, 32'd75, 10'd0});
        drive(1, 9, 0, 0, 0, e);
        idle(1);
        drive(1, 9, 0, 0, 0, e);
        idle(3);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_select_ignored: got busy=%0b with cfg_mode=1, required 0", busy);
        end
        drive(0, 0, 1, 20, 0, e);
        q_rej.push_back('{e, 32'd0, 10'd0});
        idle(2);
        cfg_mode = 1'b0;
        settle();
        vectors++;
        if (busy !== 1'b0 || pending() != 0) begin
            miscompares++;
            $display("FAIL cfg_abort_done: got busy=%0b pending=%0d, required busy=0 pending=0", busy, pending());
        end
        flush();
    endtask

    task automatic test_price_zero();
        int e;
        mem[12] = {6'h3F, 10'd1, 16'd0};
        drive(1, 12, 0, 0, 0, e);
        q_disp.push_back('{e + 2, 32'd0, 10'd12});
        q_wr.push_back('{e + 2, {6'h3F, 10'd0, 16'd0}, 10'd12});
        settle();
        vectors++;
        if (busy !== 1'b0 || pending() != 0) begin
            miscompares++;
            $display("FAIL price_zero_done: got busy=%0b pending=%0d, required busy=0 pending=0", busy, pending());
        end
        flush();
    endtask

    task automatic test_saturate();
        int e;
        mem[30] = {6'd0, 10'd1, 16'hFFFF};
        select_item(30);
        for (int i = 0; i < 256; i++) drive(0, 0, 1, 255, 0, e);
        drive(0, 0, 1, 200, 0, e);
        drive(0, 0, 1, 100, 0, e);
        q_disp.push_back('{e + 1, 32'd0, 10'd30});
        q_wr.push_back('{e + 1, {6'd0, 10'd0, 16'hFFFF}, 10'd30});
        settle();
        vectors++;
        if (busy !== 1'b0 || pending() != 0) begin
            miscompares++;
            $display("FAIL saturate_done: got busy=%0b pending=%0d, required busy=0 pending=0", busy, pending());
        end
        flush();
    endtask

    task automatic test_back_to_back();
        int e;
        int coins [3] = '{10, 255, 10};
        mem[20] = {6'd0, 10'd5, 16'd10};
        for (int k = 0; k < 3; k++) begin
            select_item(20);
            drive(0, 0, 1, coins[k], 0, e);
            q_disp.push_back('{e + 1, 32'd0, 10'd20});
            q_wr.push_back('{e + 1, {6'd0, 10'(4 - k), 16'd10}, 10'd20});
            if (coins[k] > 10) q_chg.push_back('{e + 2, 32'(coins[k] - 10), 10'd0});
            idle(1);
            drive(1, 7, 0, 0, 0, e);
            idle(1);
        end
        settle();
        vectors++;
        if (busy !== 1'b0 || pending() != 0) begin
            miscompares++;
            $display("FAIL back_to_back_done: got busy=%0b pending=%0d, required busy=0 pending=0", busy, pending());
        end
        flush();
    endtask

    task automatic test_reset_mid();
        int e;
        select_item(9);
        drive(0, 0, 1, 50, 0, e);
        idle(1);
        prst = 1'b1;
        idle(1);
        prst = 1'b0;
        idle(1);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_busy: got busy=%0b, required 0", busy);
        end
        select_item(9);
        drive(0, 0, 1, 200, 0, e);
        q_disp.push_back('{e + 1, 32'd0, 10'd9});
        q_wr.push_back('{e + 1, {6'd0, 10'd2, 16'd200}, 10'd9});
        settle();
        vectors++;
        if (busy !== 1'b0 || pending() != 0) begin
            miscompares++;
            $display("FAIL reset_mid_done: got busy=%0b pending=%0d, required busy=0 pending=0", busy, pending());
        end
        flush();
    endtask

`ifdef VTC_TIMEOUT_EN
    task automatic test_timeout();
        int e;
        select_item(9);
        drive(0, 0, 1, 10, 0, e);
        q_chg.push_back('{e + 16, 32'd10, 10'd0});
        settle();
        vectors++;
        if (busy !== 1'b0 || pending() != 0) begin
            miscompares++;
            $display("FAIL timeout_done: got busy=%0b pending=%0d, required busy=0 pending=0", busy, pending());
        end
        flush();
    endtask
`endif

    initial begin
        prst           = 1'b1;
        cfg_mode       = 1'b0;
        item_sel_valid = 1'b0;
        item_sel       = '0;
        coin_valid     = 1'b0;
        coin_cents     = '0;
        cancel         = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        test_reset();
        test_vend_exact();
        test_vend_change();
        test_soldout();
        test_cancel();
        test_cfg_abort();
        test_price_zero();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
`ifdef VTC_TIMEOUT_EN
        test_timeout();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
